// File: rtl/imem_ctrl_pkg.sv
// Shared definitions for the IMEM load controller: FSM encodings and default sizing.
package imem_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_LOAD  = 2'd0,
    ST_DRAIN = 2'd1,
    ST_RUN   = 2'd2
  } state_e;

  localparam int unsigned DEF_ADDR_W       = 8;
  localparam int unsigned DEF_DATA_W       = 8;
  localparam int unsigned DEF_TMR_W        = 32;
  localparam int unsigned DEF_IDLE_TIMEOUT = 500_000_000;

endpackage

// File: rtl/imem_load_ctrl_idle_timer.sv
// Saturating idle counter; flags expiry once it has counted IDLE_TIMEOUT enabled cycles.
module idle_timer
  import imem_ctrl_pkg::*;
#(
  parameter int unsigned TMR_W        = DEF_TMR_W,
  parameter int unsigned IDLE_TIMEOUT = DEF_IDLE_TIMEOUT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr_i,
  input  logic en_i,
  output logic expired_o
);

  localparam logic [TMR_W-1:0] LIMIT = TMR_W'(IDLE_TIMEOUT);
  localparam logic [TMR_W-1:0] MAX_V = {TMR_W{1'b1}};

  logic [TMR_W-1:0] cnt_q;
  logic [TMR_W-1:0] cnt_d;

  // Clear dominates; otherwise count while enabled and hold at the top value.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = {TMR_W{1'b0}};
    end else if (en_i && (cnt_q != MAX_V)) begin
      cnt_d = cnt_q + TMR_W'(1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Counter register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= {TMR_W{1'b0}};
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired_o = (cnt_q >= LIMIT);

endmodule

// File: rtl/imem_load_ctrl.sv
// IMEM port owner: loads bytes into IMEM, then hands the port to the CPU fetch path.
module imem_load_ctrl
  import imem_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_W       = DEF_ADDR_W,
  parameter int unsigned DATA_W       = DEF_DATA_W,
  parameter int unsigned IDLE_TIMEOUT = DEF_IDLE_TIMEOUT,
  parameter int unsigned TMR_W        = DEF_TMR_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ld_valid,
  input  logic [DATA_W-1:0] ld_data,
  output logic              ld_ready,
  input  logic              force_run,
  input  logic              load_req,
  input  logic              cpu_req,
  input  logic [ADDR_W-1:0] cpu_addr,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_rvalid,
  output logic              cpu_rst_n,
  output logic              cpu_stall,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [DATA_W-1:0] imem_wdata,
  input  logic [DATA_W-1:0] imem_rdata,
  output logic [ADDR_W:0]   load_count,
  output logic              load_done,
  output logic              overflow_err,
  output logic [1:0]        state
);

  localparam logic [ADDR_W:0] DEPTH  = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0] LAST_V = {1'b0, {ADDR_W{1'b1}}};

  state_e              state_q, state_d;
  logic [ADDR_W:0]     cnt_q, cnt_d;
  logic                we_q, we_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic                ovf_q, ovf_d;
  logic                rvalid_q, rvalid_d;
  logic                cpu_rst_n_q, cpu_stall_q, done_q;

  logic in_load_s, in_run_s, full_s, slot_busy_s, accept_s;
  logic tmr_clr_s, tmr_en_s, tmr_expired_s;

  assign in_load_s = (state_q == ST_LOAD);
  assign in_run_s  = (state_q == ST_RUN);
  assign full_s    = (cnt_q == DEPTH);
  assign ld_ready  = in_load_s && !full_s;
  // A write still in flight to the last slot means the next byte has nowhere to go.
  assign slot_busy_s = we_q && (cnt_q == LAST_V);
  assign accept_s    = ld_valid && ld_ready && !slot_busy_s && !load_req;

  assign tmr_clr_s = ld_valid || load_req || !in_load_s;
  assign tmr_en_s  = in_load_s && (cnt_q != {(ADDR_W+1){1'b0}});

  idle_timer #(
    .TMR_W       (TMR_W),
    .IDLE_TIMEOUT(IDLE_TIMEOUT)
  ) u_idle_timer (
    .clk      (clk),
    .rst_n    (reset),
    .clr_i    (tmr_clr_s),
    .en_i     (tmr_en_s),
    .expired_o(tmr_expired_s)
  );

  // Next-state logic: phase sequencing, write pipeline, counters and error flag.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    we_d     = 1'b0;
    wdata_d  = wdata_q;
    ovf_d    = ovf_q;
    rvalid_d = 1'b0;

    case (state_q)
      ST_LOAD: begin
        if (load_req) begin
          state_d = ST_LOAD;
        end else if (force_run) begin
          state_d = ST_DRAIN;
        end else if (tmr_expired_s && !ld_valid) begin
          state_d = ST_DRAIN;
        end else begin
          state_d = ST_LOAD;
        end
      end
      ST_DRAIN: begin
        if (load_req) begin
          state_d = ST_LOAD;
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        if (load_req) begin
          state_d = ST_LOAD;
        end else begin
          state_d = ST_RUN;
        end
      end
      default: state_d = ST_LOAD;
    endcase

    if (accept_s) begin
      we_d    = 1'b1;
      wdata_d = ld_data;
    end else begin
      we_d    = 1'b0;
      wdata_d = wdata_q;
    end

    if (in_load_s && ld_valid && !accept_s && !load_req) begin
      ovf_d = 1'b1;
    end else begin
      ovf_d = ovf_q;
    end

    if (in_run_s && cpu_req && !load_req) begin
      rvalid_d = 1'b1;
    end else begin
      rvalid_d = 1'b0;
    end

    // The pointer advances at the end of the cycle that performs the write.
    if (load_req) begin
      cnt_d = {(ADDR_W+1){1'b0}};
      ovf_d = 1'b0;
    end else if (we_q) begin
      cnt_d = cnt_q + (ADDR_W+1)'(1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  // State and registered outputs; CPU controls follow the state being entered.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= ST_LOAD;
      cnt_q       <= {(ADDR_W+1){1'b0}};
      we_q        <= 1'b0;
      wdata_q     <= {DATA_W{1'b0}};
      ovf_q       <= 1'b0;
      rvalid_q    <= 1'b0;
      cpu_rst_n_q <= 1'b0;
      cpu_stall_q <= 1'b1;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      we_q        <= we_d;
      wdata_q     <= wdata_d;
      ovf_q       <= ovf_d;
      rvalid_q    <= rvalid_d;
      cpu_rst_n_q <= (state_d == ST_RUN);
      cpu_stall_q <= (state_d != ST_RUN);
      done_q      <= (state_d == ST_RUN);
    end
  end

  assign imem_we      = we_q;
  assign imem_wdata   = wdata_q;
  assign imem_addr    = in_run_s ? cpu_addr : cnt_q[ADDR_W-1:0];
  assign cpu_rdata    = imem_rdata;
  assign cpu_rvalid   = rvalid_q;
  assign cpu_rst_n    = cpu_rst_n_q;
  assign cpu_stall    = cpu_stall_q;
  assign load_done    = done_q;
  assign load_count   = cnt_q;
  assign overflow_err = ovf_q;
  assign state        = state_q;

endmodule

// File: doc/imem_load_ctrl.md
Name: imem_load_ctrl

Overview:
- Owns the single IMEM port and sequences the two phases of operation.
- LOAD phase: the byte assembler writes instruction bytes into IMEM. The CPU is held in reset and stalled.
- RUN phase: the CPU fetch path owns the IMEM port.
- Phase transitions come from an idle timeout, a force-run input or a reload request. The block also keeps the write pointer, byte count and overflow error.

Parameters:
- ADDR_W, 8, IMEM address width. Depth is 2**ADDR_W.
- DATA_W, 8, IMEM data width.
- IDLE_TIMEOUT, 500_000_000, cycles without ld_valid (with at least one byte loaded) before LOAD ends.
- TMR_W, 32, idle timer width. IDLE_TIMEOUT must be less than 2**TMR_W.

Ports:
- clk  in  1  system clock.
- reset  in  1  reset; synchronous, active-low.
- ld_valid  in  1  one-cycle pulse, assembled byte available.
- ld_data  in  DATA_W  assembled byte.
- ld_ready  out  1  controller accepts bytes (combinational from state and full flag).
- force_run  in  1  pulse, end LOAD immediately.
- load_req  in  1  pulse, restart LOAD from address 0.
- cpu_req  in  1  fetch request.
- cpu_addr  in  ADDR_W  fetch address.
- cpu_rdata  out  DATA_W  fetched data (pass-through of imem_rdata).
- cpu_rvalid  out  1  cpu_rdata valid.
- cpu_rst_n  out  1  CPU reset, low outside RUN.
- cpu_stall  out  1  high outside RUN.
- imem_we  out  1  IMEM write enable.
- imem_addr  out  ADDR_W  IMEM address.
- imem_wdata  out  DATA_W  IMEM write data.
- imem_rdata  in  DATA_W  IMEM registered read data (1-cycle latency).
- load_count  out  ADDR_W+1  bytes written this load, 0..2**ADDR_W.
- load_done  out  1  high while in RUN.
- overflow_err  out  1  sticky; a byte arrived while IMEM was full.
- state  out  2  current FSM state, for debug LEDs.

Behaviour:
- Reset (reset low at a clk edge) takes effect regardless of current state, including mid-write. Reset values:
  - state = LOAD
  - write pointer = 0, load_count = 0, imem_we = 0, imem_wdata = 0
  - overflow_err = 0, load_done = 0
  - cpu_rst_n = 0, cpu_stall = 1, cpu_rvalid = 0
  - idle timer = 0
- FSM states: LOAD = 0, DRAIN = 1, RUN = 2. Encoding 3 is unused and recovers to LOAD.
- LOAD, write path:
  - ld_ready = !full, where full = (load_count == 2**ADDR_W).
  - ld_valid in cycle N with !full: in cycle N+1, imem_we = 1, imem_addr = pointer, imem_wdata = ld_data. The pointer and load_count increment at the end of N+1.
  - imem_we is a single-cycle pulse. Back-to-back ld_valid pulses produce back-to-back writes.
- LOAD, overflow:
  - ld_valid while full drops the byte and sets overflow_err.
  - There is no write, and the pointer does not wrap.
- LOAD, idle timer:
  - Counts only while load_count > 0 and no ld_valid arrives. Cleared on ld_valid. Saturates at its maximum.
  - When the timer reaches IDLE_TIMEOUT, go to DRAIN.
  - ld_valid in the same cycle as expiry: the byte wins, the timer clears and the state stays LOAD.
- LOAD, force_run: go to DRAIN at the next edge, even with load_count = 0.
  - A byte accepted in the same cycle is still written, during DRAIN.
- DRAIN: lasts exactly 1 cycle and completes any pending write. ld_ready = 0. Then go to RUN.
- RUN:
  - cpu_rst_n = 1, cpu_stall = 0, load_done = 1, ld_ready = 0. ld_valid is ignored (no write, no error).
  - imem_addr = cpu_addr (combinational). imem_we = 0.
  - cpu_rvalid = cpu_req registered one cycle. cpu_rdata = imem_rdata.
- load_req:
  - In RUN: at the next edge go to LOAD. Clear pointer, load_count, overflow_err, timer and load_done. cpu_rst_n = 0 and cpu_stall = 1 in that same cycle. cpu_rvalid clears.
  - In LOAD: same clears; the state stays LOAD.
  - In DRAIN: takes priority over RUN entry.
- Priority when inputs coincide: reset > load_req > force_run > timeout.
- cpu_req outside RUN: ignored, cpu_rvalid = 0.

Decomposition:
- Package imem_ctrl_pkg holds:
  - state encodings ST_LOAD, ST_DRAIN, ST_RUN;
  - default widths;
  - the IDLE_TIMEOUT default.
- Natural sub-module: idle_timer, a saturating counter with clear, count enable and expired output, sized by TMR_W and IDLE_TIMEOUT.
- FSM, pointer and port mux stay in the top level.

Test Plan:
- Reset low 3 cycles, then high → state = 0, cpu_rst_n = 0, cpu_stall = 1, ld_ready = 1, load_count = 0, all imem_we = 0.
- IDLE_TIMEOUT = 20; pulse ld_valid with 0x3A, then 0x5C two cycles apart → writes 0x3A@0 and 0x5C@1, one cycle after each pulse. load_count = 2. 20 idle cycles → DRAIN for 1 cycle, then RUN with cpu_rst_n = 1.
- In RUN, cpu_req = 1 with cpu_addr = 1 → imem_addr = 1 the same cycle. Next cycle cpu_rvalid = 1 and cpu_rdata = 0x5C. ld_valid in RUN → no imem_we.
- ADDR_W = 2; send 5 bytes 0x11..0x55 → 4 writes at addresses 0..3, load_count = 4, ld_ready = 0. The 5th byte sets overflow_err, with no write and no wrap.
- ld_valid coincides with the timer reaching IDLE_TIMEOUT → byte written, state stays LOAD, timer restarts. force_run mid-load → DRAIN → RUN.
- load_req in RUN → next cycle state = LOAD, load_count = 0, overflow_err = 0, cpu_rst_n = 0. Reset low mid-write → imem_we = 0 the following cycle and all outputs at their reset values.
